ex_operand_stage: RTL

- ID/EX pipeline stage that sits directly upstream of the RV32I ALU.
- Captures decoded fields from the decoder, applies MEM/WB operand forwarding and operand-select muxing, and drives the ALU's operand A, operand B and 4-bit op.
- Uses a valid/ready handshake with flush and load-use hazard bubbling.

---
 rtl/ex_operand_stage.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX operand stage feeding the RV32I ALU
//
// Purpose:
//   Single-entry ID/EX register. Decoded fields are captured with a valid/ready
//   handshake. The held rs1/rs2 values are resolved against the EX/MEM and
//   MEM/WB write-back sources. Operand A/B and the ALU op are then driven to the ALU.
//   A load-use hazard forces a bubble while the entry holds.
//
// Configuration macro:
//   EX_FORWARD_EN
//     defined   : MEM/WB forwarding muxes are built. o_hazard flags load-use only.
//     undefined : operands come from the registered regfile data. o_hazard flags
//                 any used-rs match against an enabled MEM or WB source.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     upstream handshake
//   i_pc, i_rs*_data, i_imm, i_rs1, i_rs2, i_rd, i_rs*_used,
//   i_a_sel, i_b_sel, i_alu_op, i_wb_en     decoded instruction fields
//   i_flush               kill held and incoming instruction
//   i_mem_*               EX/MEM forwarding / hazard source
//   i_wb_*                MEM/WB forwarding / hazard source
//   o_valid / i_ready     downstream handshake
//   o_operand_a/b, o_alu_op                 to ALU
//   o_store_data, o_pc, o_rd, o_wb_en       held/forwarded values for later stages
//   o_hazard              load-use stall indicator
module ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_rs1_data,
  input  logic [XLEN-1:0]   i_rs2_data,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_rs1_used,
  input  logic              i_rs2_used,
  input  logic [1:0]        i_a_sel,
  input  logic [1:0]        i_b_sel,
  input  logic [3:0]        i_alu_op,
  input  logic              i_wb_en,
  input  logic              i_flush,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_wb_en,
  input  logic              i_mem_is_load,
  input  logic [XLEN-1:0]   i_mem_data,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_wb_en,
  input  logic [XLEN-1:0]   i_wb_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [XLEN-1:0]   o_operand_a,
  output logic [XLEN-1:0]   o_operand_b,
  output logic [3:0]        o_alu_op,
  output logic [XLEN-1:0]   o_store_data,
  output logic [XLEN-1:0]   o_pc,
  output logic [REG_AW-1:0] o_rd,
  output logic              o_wb_en,
  output logic              o_hazard
);

  logic              v_q,        v_d;
  logic [XLEN-1:0]   pc_q,       pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q,      imm_d;
  logic [REG_AW-1:0] rs1_q,      rs1_d;
  logic [REG_AW-1:0] rs2_q,      rs2_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic              rs1_used_q, rs1_used_d;
  logic              rs2_used_q, rs2_used_d;
  logic [1:0]        a_sel_q,    a_sel_d;
  logic [1:0]        b_sel_q,    b_sel_d;
  logic [3:0]        alu_op_q,   alu_op_d;
  logic              wb_en_q,    wb_en_d;

  logic            m_hit1, m_hit2, w_hit1, w_hit2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            hazard;

  // Source matches against the held indices; x0 never matches.
  assign m_hit1 = i_mem_wb_en & (i_mem_rd == rs1_q) & (rs1_q != '0);
  assign m_hit2 = i_mem_wb_en & (i_mem_rd == rs2_q) & (rs2_q != '0);
  assign w_hit1 = i_wb_wb_en  & (i_wb_rd  == rs1_q) & (rs1_q != '0);
  assign w_hit2 = i_wb_wb_en  & (i_wb_rd  == rs2_q) & (rs2_q != '0);

`ifdef EX_FORWARD_EN
  // MEM result is younger than WB, so it wins.
  always_comb begin
    rs1_val = rs1_data_q;
    if (rs1_q == '0)  rs1_val = '0;
    else if (m_hit1)  rs1_val = i_mem_data;
    else if (w_hit1)  rs1_val = i_wb_data;

    rs2_val = rs2_data_q;
    if (rs2_q == '0)  rs2_val = '0;
    else if (m_hit2)  rs2_val = i_mem_data;
    else if (w_hit2)  rs2_val = i_wb_data;
  end

  // Only a load in MEM cannot be forwarded yet; m_hit* already excludes x0.
  assign hazard = v_q & i_mem_is_load &
                  ((rs1_used_q & m_hit1) | (rs2_used_q & m_hit2));
`else
  assign rs1_val = (rs1_q == '0) ? '0 : rs1_data_q;
  assign rs2_val = (rs2_q == '0) ? '0 : rs2_data_q;

  // Without bypassing, any pending write to a used source must drain first.
  assign hazard = v_q & ((rs1_used_q & (m_hit1 | w_hit1)) |
                         (rs2_used_q & (m_hit2 | w_hit2)));

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{i_mem_data, i_wb_data, i_mem_is_load};
`endif

  assign o_hazard = hazard;
  assign o_valid  = v_q & ~hazard;
  assign o_ready  = ~v_q | (i_ready & ~hazard);

  always_comb begin
    o_operand_a = '0;
    case (a_sel_q)
      2'b00:   o_operand_a = rs1_val;
      2'b01:   o_operand_a = pc_q;
      default: o_operand_a = '0;
    endcase
    o_operand_b = '0;
    case (b_sel_q)
      2'b00:   o_operand_b = rs2_val;
      2'b01:   o_operand_b = imm_q;
      2'b10:   o_operand_b = XLEN'(4);
      default: o_operand_b = '0;
    endcase
  end

  assign o_store_data = rs2_val;
  assign o_alu_op     = alu_op_q;
  assign o_pc         = pc_q;
  assign o_rd         = rd_q;
  assign o_wb_en      = wb_en_q;

  always_comb begin
    v_d        = v_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_used_d = rs1_used_q;
    rs2_used_d = rs2_used_q;
    a_sel_d    = a_sel_q;
    b_sel_d    = b_sel_q;
    alu_op_d   = alu_op_q;
    wb_en_d    = wb_en_q;
    if (i_flush) begin
      v_d = 1'b0;
    end else if (i_valid & o_ready) begin
      // Also covers capture-while-draining: the new entry replaces the old.
      v_d        = 1'b1;
      pc_d       = i_pc;
      rs1_data_d = i_rs1_data;
      rs2_data_d = i_rs2_data;
      imm_d      = i_imm;
      rs1_d      = i_rs1;
      rs2_d      = i_rs2;
      rd_d       = i_rd;
      rs1_used_d = i_rs1_used;
      rs2_used_d = i_rs2_used;
      a_sel_d    = i_a_sel;
      b_sel_d    = i_b_sel;
      alu_op_d   = i_alu_op;
      wb_en_d    = i_wb_en;
    end else if (o_valid & i_ready) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_q        <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_used_q <= 1'b0;
      rs2_used_q <= 1'b0;
      a_sel_q    <= 2'b00;
      b_sel_q    <= 2'b00;
      alu_op_q   <= 4'b0000;
      wb_en_q    <= 1'b0;
    end else begin
      v_q        <= v_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_used_q <= rs1_used_d;
      rs2_used_q <= rs2_used_d;
      a_sel_q    <= a_sel_d;
      b_sel_q    <= b_sel_d;
      alu_op_q   <= alu_op_d;
      wb_en_q    <= wb_en_d;
    end
  end

endmodule
